// File: rtl/trap_sequencer_if.sv
// Bundles the pipeline-facing and CSR-file-facing signals of trap_sequencer.
//   master : pipeline / CSR-file side (drives requests, events, CSR read data)
//   slave  : trap_sequencer side (drives the CSR port, redirect, flush, stall)
interface trap_sequencer_if;
    // Pipeline CSR-instruction request (MEM stage)
    logic        csr_rw_in;
    logic [1:0]  csr_wsc_mode_in;
    logic [11:0] csr_rw_addr_in;
    logic [31:0] csr_w_data_in;
    // MEM-stage events and context
    logic        interrupt;
    logic        illegal_inst;
    logic        ecall_m;
    logic        l_access_fault;
    logic        s_access_fault;
    logic        mret;
    logic [31:0] epc_cur;
    logic [31:0] epc_next;
    logic [31:0] inst_mem;
    logic [31:0] addr_mem;
    // CSR file feedback
    logic [31:0] mstatus;
    logic [31:0] csr_rdata;
    // CSR port
    logic        csr_w;
    logic [1:0]  csr_wsc;
    logic [11:0] csr_waddr;
    logic [11:0] csr_raddr;
    logic [31:0] csr_wdata;
    // Control-flow and pipeline control
    logic [31:0] PC_redirect;
    logic        redirect_mux;
    logic        reg_FD_flush;
    logic        reg_DE_flush;
    logic        reg_EM_flush;
    logic        reg_MW_flush;
    logic        RegWrite_cancel;
    logic        stall;

    modport master (
        output csr_rw_in, csr_wsc_mode_in, csr_rw_addr_in, csr_w_data_in,
        output interrupt, illegal_inst, ecall_m, l_access_fault, s_access_fault, mret,
        output epc_cur, epc_next, inst_mem, addr_mem, mstatus, csr_rdata,
        input  csr_w, csr_wsc, csr_waddr, csr_raddr, csr_wdata,
        input  PC_redirect, redirect_mux,
        input  reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush,
        input  RegWrite_cancel, stall
    );

    modport slave (
        input  csr_rw_in, csr_wsc_mode_in, csr_rw_addr_in, csr_w_data_in,
        input  interrupt, illegal_inst, ecall_m, l_access_fault, s_access_fault, mret,
        input  epc_cur, epc_next, inst_mem, addr_mem, mstatus, csr_rdata,
        output csr_w, csr_wsc, csr_waddr, csr_raddr, csr_wdata,
        output PC_redirect, redirect_mux,
        output reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush,
        output RegWrite_cancel, stall
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap controller. Owns the single CSR port: mirrors pipeline CSR
// requests while idle; on a trap or mret it flushes, stalls, writes the trap
// CSRs one per cycle and issues a one-cycle PC redirect.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   tsq_io : trap_sequencer_if.slave (pipeline request/events in, CSR port,
//            redirect, flushes, RegWrite_cancel and stall out)
module trap_sequencer (
    input logic             clk,
    input logic             rst,
    trap_sequencer_if.slave tsq_io
);
    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;
    localparam logic [11:0] CsrMtval   = 12'h343;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWEpc     = 3'd1;
    localparam logic [2:0] StWCause   = 3'd2;
    localparam logic [2:0] StWTval    = 3'd3;
    localparam logic [2:0] StWStatus  = 3'd4;
    localparam logic [2:0] StRdTvec   = 3'd5;
    localparam logic [2:0] StMrStatus = 3'd6;
    localparam logic [2:0] StRdEpc    = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;

    logic        int_taken;
    logic        sync_exc;
    logic        accept;
    logic [31:0] trap_status;
    logic [31:0] mret_status;

    always_comb begin
        int_taken = tsq_io.interrupt & tsq_io.mstatus[3];
        sync_exc  = tsq_io.illegal_inst | tsq_io.ecall_m |
                    tsq_io.l_access_fault | tsq_io.s_access_fault;
        accept    = (state_q == StIdle) & (int_taken | sync_exc | tsq_io.mret);

        // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M
        trap_status        = tsq_io.mstatus;
        trap_status[7]     = tsq_io.mstatus[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = 2'b11;
        // Trap return: MIE <= MPIE, MPIE <= 1, MPP <= M
        mret_status        = tsq_io.mstatus;
        mret_status[3]     = tsq_io.mstatus[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b11;
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        tval_d  = tval_q;
        if (accept) begin
            state_d = StWEpc;
            epc_d   = tsq_io.epc_cur;
            tval_d  = 32'h0;
            if (int_taken) begin
                cause_d = 32'h8000_000B;
                epc_d   = tsq_io.epc_next;
            end else if (tsq_io.illegal_inst) begin
                cause_d = 32'd2;
                tval_d  = tsq_io.inst_mem;
            end else if (tsq_io.ecall_m) begin
                cause_d = 32'd11;
            end else if (tsq_io.l_access_fault) begin
                cause_d = 32'd5;
                tval_d  = tsq_io.addr_mem;
            end else if (tsq_io.s_access_fault) begin
                cause_d = 32'd7;
                tval_d  = tsq_io.addr_mem;
            end else begin
                // mret leaves the trap latches untouched
                state_d = StMrStatus;
                epc_d   = epc_q;
                tval_d  = tval_q;
            end
        end else begin
            case (state_q)
                StWEpc:     state_d = StWCause;
                StWCause:   state_d = StWTval;
                StWTval:    state_d = StWStatus;
                StWStatus:  state_d = StRdTvec;
                StMrStatus: state_d = StRdEpc;
                default:    state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cause_q <= 32'h0;
            epc_q   <= 32'h0;
            tval_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
        end
    end

    logic flush;

    always_comb begin
        tsq_io.csr_w           = 1'b0;
        tsq_io.csr_wsc         = 2'b00;
        tsq_io.csr_waddr       = 12'h0;
        tsq_io.csr_raddr       = 12'h0;
        tsq_io.csr_wdata       = 32'h0;
        tsq_io.PC_redirect     = 32'h0;
        tsq_io.redirect_mux    = 1'b0;
        tsq_io.RegWrite_cancel = 1'b0;
        tsq_io.stall           = (state_q != StIdle);
        flush                  = 1'b0;

        case (state_q)
            StIdle: begin
                // Gate with rst so the mirror path also reads 0 during reset
                if (rst && accept) begin
                    flush                  = 1'b1;
                    tsq_io.RegWrite_cancel = sync_exc & ~int_taken;
                end else if (rst) begin
                    tsq_io.csr_w     = tsq_io.csr_rw_in;
                    tsq_io.csr_wsc   = tsq_io.csr_wsc_mode_in;
                    tsq_io.csr_waddr = tsq_io.csr_rw_addr_in;
                    tsq_io.csr_raddr = tsq_io.csr_rw_addr_in;
                    tsq_io.csr_wdata = tsq_io.csr_w_data_in;
                end
            end
            StWEpc, StWCause, StWTval, StWStatus, StMrStatus: begin
                tsq_io.csr_w   = 1'b1;
                tsq_io.csr_wsc = 2'b01;
                case (state_q)
                    StWEpc: begin
                        tsq_io.csr_waddr = CsrMepc;
                        tsq_io.csr_wdata = epc_q;
                    end
                    StWCause: begin
                        tsq_io.csr_waddr = CsrMcause;
                        tsq_io.csr_wdata = cause_q;
                    end
                    StWTval: begin
                        tsq_io.csr_waddr = CsrMtval;
                        tsq_io.csr_wdata = tval_q;
                    end
                    StWStatus: begin
                        tsq_io.csr_waddr = CsrMstatus;
                        tsq_io.csr_wdata = trap_status;
                    end
                    default: begin
                        tsq_io.csr_waddr = CsrMstatus;
                        tsq_io.csr_wdata = mret_status;
                    end
                endcase
            end
            StRdTvec: begin
                tsq_io.csr_raddr    = CsrMtvec;
                tsq_io.PC_redirect  = {tsq_io.csr_rdata[31:2], 2'b00};
                tsq_io.redirect_mux = 1'b1;
            end
            default: begin
                tsq_io.csr_raddr    = CsrMepc;
                tsq_io.PC_redirect  = tsq_io.csr_rdata;
                tsq_io.redirect_mux = 1'b1;
            end
        endcase

        tsq_io.reg_FD_flush = flush;
        tsq_io.reg_DE_flush = flush;
        tsq_io.reg_EM_flush = flush;
        tsq_io.reg_MW_flush = flush;
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a small CSR-file model reacts to the DUT's CSR
// port; each event's expected cause/epc/tval/mstatus/target is derived from
// the trap rules and compared against the model and the DUT outputs.
module tb_trap_sequencer;
    localparam logic [11:0] AMstatus = 12'h300;
    localparam logic [11:0] AMtvec   = 12'h305;
    localparam logic [11:0] AMepc    = 12'h341;
    localparam logic [11:0] AMcause  = 12'h342;
    localparam logic [11:0] AMtval   = 12'h343;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    trap_sequencer_if u_if ();

    trap_sequencer u_dut (
        .clk    (clk),
        .rst    (rst),
        .tsq_io (u_if.slave)
    );

    always #5 clk = ~clk;

    // CSR file model
    logic [31:0] m_status = 32'h0, m_tvec = 32'h0, m_epc = 32'h0;
    logic [31:0] m_cause = 32'h0, m_tval = 32'h0;

    function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] mode);
        case (mode)
            2'b01:   return d;
            2'b10:   return old | d;
            2'b11:   return old & ~d;
            default: return old;
        endcase
    endfunction

    always @(posedge clk) begin
        if (u_if.csr_w) begin
            case (u_if.csr_waddr)
                AMstatus: m_status <= apply(m_status, u_if.csr_wdata, u_if.csr_wsc);
                AMtvec:   m_tvec   <= apply(m_tvec,   u_if.csr_wdata, u_if.csr_wsc);
                AMepc:    m_epc    <= apply(m_epc,    u_if.csr_wdata, u_if.csr_wsc);
                AMcause:  m_cause  <= apply(m_cause,  u_if.csr_wdata, u_if.csr_wsc);
                AMtval:   m_tval   <= apply(m_tval,   u_if.csr_wdata, u_if.csr_wsc);
                default: ;
            endcase
        end
    end

    always_comb begin
        case (u_if.csr_raddr)
            AMstatus: u_if.csr_rdata = m_status;
            AMtvec:   u_if.csr_rdata = m_tvec;
            AMepc:    u_if.csr_rdata = m_epc;
            AMcause:  u_if.csr_rdata = m_cause;
            AMtval:   u_if.csr_rdata = m_tval;
            default:  u_if.csr_rdata = 32'h0;
        endcase
    end
    assign u_if.mstatus = m_status;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flushes();
        return {u_if.reg_FD_flush, u_if.reg_DE_flush, u_if.reg_EM_flush, u_if.reg_MW_flush};
    endfunction

    task automatic set_events(input logic [5:0] ev);
        {u_if.interrupt, u_if.illegal_inst, u_if.ecall_m,
         u_if.l_access_fault, u_if.s_access_fault, u_if.mret} = ev;
    endtask

    task automatic idle_inputs();
        u_if.csr_rw_in       = 1'b0;
        u_if.csr_wsc_mode_in = 2'b00;
        u_if.csr_rw_addr_in  = 12'h0;
        u_if.csr_w_data_in   = 32'h0;
        set_events(6'b0);
        u_if.epc_cur  = 32'h0;
        u_if.epc_next = 32'h0;
        u_if.inst_mem = 32'h0;
        u_if.addr_mem = 32'h0;
    endtask

    // Pipeline CSR write passed through in IDLE; lands in the model at the next edge.
    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        idle_inputs();
        u_if.csr_rw_in       = 1'b1;
        u_if.csr_wsc_mode_in = 2'b01;
        u_if.csr_rw_addr_in  = addr;
        u_if.csr_w_data_in   = data;
        @(negedge clk);
        check("mirror_w",     32'(u_if.csr_w), 32'd1);
        check("mirror_waddr", 32'(u_if.csr_waddr), 32'(addr));
        check("mirror_raddr", 32'(u_if.csr_raddr), 32'(addr));
        check("mirror_wdata", u_if.csr_wdata, data);
        check("mirror_wsc",   32'(u_if.csr_wsc), 32'd1);
        check("mirror_stall", 32'(u_if.stall), 32'd0);
        check("mirror_flush", 32'(flushes()), 32'd0);
    endtask

    // ev = {interrupt, illegal, ecall, l_fault, s_fault, mret}
    task automatic run_event(input logic [5:0] ev, input logic [31:0] ecur,
                             input logic [31:0] enext, input logic [31:0] inst,
                             input logic [31:0] addr, input bit junk);
        int          w;
        int          n;
        logic [31:0] e_cause, e_epc, e_tval, e_status, e_target, old;
        logic [11:0] waddrs[4];
        @(posedge clk); #1;
        idle_inputs();
        set_events(ev);
        u_if.epc_cur  = ecur;
        u_if.epc_next = enext;
        u_if.inst_mem = inst;
        u_if.addr_mem = addr;

        w = -1;
        if (ev[5] && m_status[3]) w = 0;
        else if (ev[4]) w = 1;
        else if (ev[3]) w = 2;
        else if (ev[2]) w = 3;
        else if (ev[1]) w = 4;
        else if (ev[0]) w = 5;

        @(negedge clk);
        if (w < 0) begin
            check("ignored_flush", 32'(flushes()), 32'd0);
            check("ignored_cancel", 32'(u_if.RegWrite_cancel), 32'd0);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            check("ignored_stall", 32'(u_if.stall), 32'd0);
            return;
        end

        case (w)
            0:       e_cause = 32'h8000_000B;
            1:       e_cause = 32'd2;
            2:       e_cause = 32'd11;
            3:       e_cause = 32'd5;
            default: e_cause = 32'd7;
        endcase
        e_epc  = (w == 0) ? enext : ecur;
        e_tval = (w == 1) ? inst : ((w == 3 || w == 4) ? addr : 32'h0);
        old    = m_status;
        if (w == 5) begin
            e_status = (old & ~32'h1888) | (old[7] ? 32'h8 : 32'h0) | 32'h1880;
            e_target = m_epc;
            n        = 2;
        end else begin
            e_status = (old & ~32'h1888) | (old[3] ? 32'h80 : 32'h0) | 32'h1800;
            e_target = m_tvec & 32'hFFFF_FFFC;
            n        = 5;
        end
        waddrs = '{AMepc, AMcause, AMtval, AMstatus};

        check("accept_flush",  32'(flushes()), 32'hF);
        check("accept_cancel", 32'(u_if.RegWrite_cancel), (w >= 1 && w <= 4) ? 32'd1 : 32'd0);
        check("accept_csr_w",  32'(u_if.csr_w), 32'd0);
        check("accept_stall",  32'(u_if.stall), 32'd0);

        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (junk) begin
                set_events(6'($urandom));
                u_if.csr_rw_in       = 1'($urandom);
                u_if.csr_wsc_mode_in = 2'b01;
                u_if.csr_rw_addr_in  = AMcause;
                u_if.csr_w_data_in   = $urandom;
            end
            @(negedge clk);
            check("seq_stall",    32'(u_if.stall), 32'd1);
            check("seq_flush",    32'(flushes()), 32'd0);
            check("seq_redirect", 32'(u_if.redirect_mux), (k == n) ? 32'd1 : 32'd0);
            if (k < n) begin
                check("seq_csr_w", 32'(u_if.csr_w), 32'd1);
                check("seq_waddr", 32'(u_if.csr_waddr),
                      (w == 5) ? 32'(AMstatus) : 32'(waddrs[k-1]));
            end else begin
                check("rd_csr_w", 32'(u_if.csr_w), 32'd0);
                check("rd_target", u_if.PC_redirect, e_target);
                check("csr_mstatus", m_status, e_status);
                if (w != 5) begin
                    check("csr_mepc",   m_epc, e_epc);
                    check("csr_mcause", m_cause, e_cause);
                    check("csr_mtval",  m_tval, e_tval);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        #3;
        check("rst_stall",    32'(u_if.stall), 32'd0);
        check("rst_redirect", 32'(u_if.redirect_mux), 32'd0);
        check("rst_flush",    32'(flushes()), 32'd0);
        check("rst_csr_w",    32'(u_if.csr_w), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Pass-through and CSR setup
        csr_write(AMtvec, 32'h100);
        csr_write(AMtvec, 32'h200);
        csr_write(AMstatus, 32'h8);

        // Illegal instruction
        run_event(6'b010000, 32'h40, 32'h44, 32'hFFFF_FFFF, 32'h0, 1'b0);

        // Interrupt masked, then enabled
        csr_write(AMstatus, 32'h0);
        run_event(6'b100000, 32'h80, 32'h88, 32'h0, 32'h0, 1'b0);
        csr_write(AMstatus, 32'h8);
        run_event(6'b100000, 32'h80, 32'h88, 32'h0, 32'h0, 1'b0);

        // Priority with and without MIE
        csr_write(AMstatus, 32'h8);
        run_event(6'b101100, 32'h90, 32'h94, 32'h13, 32'hABC, 1'b0);
        csr_write(AMstatus, 32'h0);
        run_event(6'b101100, 32'h90, 32'h94, 32'h13, 32'hABC, 1'b0);

        // mret, then confirm stall dropped
        csr_write(AMepc, 32'h44);
        csr_write(AMstatus, 32'h80);
        run_event(6'b000001, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("mret_after_stall", 32'(u_if.stall), 32'd0);

        // Back-to-back traps
        run_event(6'b001000, 32'hA0, 32'hA4, 32'h0, 32'h0, 1'b1);
        run_event(6'b000010, 32'hB0, 32'hB4, 32'h0, 32'h5000, 1'b1);

        // Reset during W_CAUSE
        csr_write(AMcause, 32'h1234);
        csr_write(AMtval, 32'h5678);
        csr_write(AMstatus, 32'h8);
        @(posedge clk); #1;
        idle_inputs();
        u_if.ecall_m = 1'b1;
        u_if.epc_cur = 32'h300;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        check("pre_rst_stall", 32'(u_if.stall), 32'd1);
        u_if.csr_rw_in      = 1'b1;
        u_if.csr_rw_addr_in = AMtval;
        u_if.csr_w_data_in  = 32'hDEAD;
        rst = 1'b0;
        #1;
        check("rst_mid_stall", 32'(u_if.stall), 32'd0);
        check("rst_mid_csr_w", 32'(u_if.csr_w), 32'd0);
        check("rst_mid_flush", 32'(flushes()), 32'd0);
        check("rst_mid_redir", 32'(u_if.redirect_mux), 32'd0);
        check("rst_mid_wdata", u_if.csr_wdata, 32'h0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        check("rst_kept_mepc",   m_epc, 32'h300);
        check("rst_kept_mcause", m_cause, 32'h1234);
        check("rst_kept_mtval",  m_tval, 32'h5678);
        check("rst_kept_status", m_status, 32'h8);
        run_event(6'b001000, 32'h310, 32'h314, 32'h0, 32'h0, 1'b0);

        // Randomized events
        for (int i = 0; i < 30; i++) begin
            if (($urandom % 3) == 0) csr_write(AMstatus, $urandom & 32'h0000_1888);
            if (($urandom % 4) == 0) csr_write(AMtvec, $urandom);
            if (($urandom % 4) == 0) csr_write(AMepc, $urandom);
            run_event(6'($urandom), $urandom, $urandom, $urandom, $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle machine-mode trap controller for the 5-stage RISC-V core. It sits between the MEM-stage exception signals and the single CSR register-file port, and owns that port. In idle it passes pipeline CSR instructions through. On a trap or `mret` it stalls and flushes the pipeline, writes mepc/mcause/mtval/mstatus one per cycle, then fetches the target PC from mtvec or mepc and issues a one-cycle redirect.

## Interface
- `CSR_MSTATUS`, 12'h300; `CSR_MTVEC`, 12'h305; `CSR_MEPC`, 12'h341; `CSR_MCAUSE`, 12'h342; `CSR_MTVAL`, 12'h343: CSR addresses.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `csr_rw_in` in 1; `csr_wsc_mode_in` in 2; `csr_rw_addr_in` in 12; `csr_w_data_in` in 32: pipeline CSR-instruction request (MEM stage).
- `interrupt`, `illegal_inst`, `ecall_m`, `l_access_fault`, `s_access_fault`, `mret` in 1 each: MEM-stage events.
- `epc_cur` in 32: PC of the MEM instruction. `epc_next` in 32: next unflushed PC.
- `inst_mem` in 32: MEM instruction word. `addr_mem` in 32: MEM load/store address.
- `mstatus` in 32: current mstatus from the CSR file. `csr_rdata` in 32: combinational CSR read data.
- `csr_w` out 1; `csr_wsc` out 2; `csr_waddr` out 12; `csr_raddr` out 12; `csr_wdata` out 32: CSR port.
- `PC_redirect` out 32; `redirect_mux` out 1: redirect target and its valid pulse.
- `reg_FD_flush`, `reg_DE_flush`, `reg_EM_flush`, `reg_MW_flush` out 1: pipeline flushes.
- `RegWrite_cancel` out 1: kill the WB write of the MEM instruction.
- `stall` out 1: freeze PC and all pipeline registers.

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, RD_TVEC, MR_STATUS, RD_EPC.
- In IDLE with no accepted event, the CSR port mirrors the pipeline request: `csr_w=csr_rw_in`, both addresses `=csr_rw_addr_in`, `csr_wdata=csr_w_data_in`, `csr_wsc=csr_wsc_mode_in`.
- An interrupt is accepted only if `mstatus[3]` (MIE) is 1.
- Event priority: interrupt > illegal_inst > ecall_m > l_access_fault > s_access_fault > mret.
- Latched on acceptance (trap events):
  - cause: 32'h8000000B, 2, 11, 5, 7 respectively.
  - epc: `epc_next` for an interrupt, `epc_cur` otherwise.
  - tval: `inst_mem` for illegal, `addr_mem` for access faults, 0 otherwise.
- Acceptance cycle (IDLE): assert all four flushes and force `csr_w=0`, which suppresses the pipeline CSR write. Assert `RegWrite_cancel` for synchronous exceptions only, not for interrupt or mret.
- Trap path, one CSR write per state with `csr_wsc=2'b01`:
  - W_EPC: mepc ← epc.
  - W_CAUSE: mcause ← cause.
  - W_TVAL: mtval ← tval.
  - W_STATUS: mstatus ← mstatus with MPIE[7]=MIE[3], MIE=0, MPP[12:11]=2'b11.
  - RD_TVEC: `csr_raddr=CSR_MTVEC`, `csr_w=0`, `PC_redirect={csr_rdata[31:2],2'b00}`, `redirect_mux=1`; then go to IDLE.
- Mret path:
  - MR_STATUS: mstatus ← MIE=MPIE, MPIE=1, MPP=2'b11.
  - RD_EPC: `csr_raddr=CSR_MEPC`, `PC_redirect=csr_rdata`, `redirect_mux=1`; then go to IDLE.
- Events and pipeline CSR requests arriving while not in IDLE are ignored.
- `stall=1` in every non-IDLE state.
- All other CSR-port outputs are 0 when not driven as above.

## Timing
- Reset (async, `rst`=0): state IDLE, latches cleared, all registered outputs 0. `redirect_mux`, flushes, `stall` and `RegWrite_cancel` read 0 immediately.
- All outputs are decoded from the registered state and latches, plus same-cycle inputs in IDLE.
- Trap accepted at cycle T:
  - Flushes at T.
  - mepc, mcause, mtval, mstatus written at the edges ending T+1, T+2, T+3, T+4.
  - Redirect at T+5.
  - IDLE at T+6; `stall` high T+1..T+5.
- Mret accepted at T: mstatus written at the edge ending T+1; redirect at T+2; IDLE at T+3.
- An event in the IDLE cycle immediately after a redirect is accepted normally (back-to-back traps).
- Reset mid-sequence aborts with no further CSR writes; writes already completed stay in the CSR file.

## Test plan
- Pipeline `csrrw` to 0x305 with data 0x100, no events -> `csr_w=1`, `csr_waddr=0x305`, `csr_wdata=0x100` in the same cycle, `stall=0`.
- illegal_inst with `epc_cur=0x40`, `inst_mem=0xFFFFFFFF`, mtvec=0x200 -> mepc=0x40, mcause=2, mtval=0xFFFFFFFF; MIE 1→0 and MPIE=1; redirect 0x200 at T+5; `RegWrite_cancel` at T.
- Interrupt with MIE=0 -> ignored. Interrupt with MIE=1, `epc_next=0x88` -> mepc=0x88, mcause=0x8000000B, no `RegWrite_cancel`.
- Interrupt, ecall_m and l_access_fault together -> interrupt wins (MIE=1). Same with MIE=0 -> mcause=11, mtval=0.
- mret with mepc=0x44, MPIE=1 -> MIE=1, redirect 0x44 at T+2, `stall` high only at T+1..T+2.
- `rst` low at W_CAUSE -> all outputs 0 immediately, no mtval/mstatus write; after release a new ecall completes with a redirect at T+5.
